// File: rtl/db_pkg.sv
// Shared definitions for the db_cont engine and its front-end arbiter:
// op/flag encodings and the default payload widths.
package db_pkg;

  localparam int HASH_SIZE = 32;
  localparam int KEY_SIZE  = 96;
  localparam int VAL_SIZE  = 32;
  localparam int FLAG_SIZE = 4;

  typedef enum logic [FLAG_SIZE-1:0] {
    OP_NOP    = 4'h0,
    OP_LOOKUP = 4'h1,
    OP_INSERT = 4'h2,
    OP_UPSERT = 4'h3,
    OP_DELETE = 4'h4
  } db_op_e;

  typedef enum logic [FLAG_SIZE-1:0] {
    FLAG_NONE = 4'h0,
    FLAG_HIT  = 4'h1,
    FLAG_MISS = 4'h2,
    FLAG_FULL = 4'h4,
    FLAG_ERR  = 4'h8
  } db_flag_e;

  // Index width that stays at least 1 bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/db_tag_fifo.sv
// Synchronous tag FIFO used to remember the issuer of each in-order command;
// DEPTH must be a power of two so the pointers wrap naturally.
module db_tag_fifo
  import db_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // A push into a full FIFO is only legal when a pop frees the slot the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/db_arb.sv
// Round-robin front end sharing one in-order db_cont engine between NPORT
// requesters. Define DB_ARB_STATS_EN to build the per-port grant counters.
module db_arb
  import db_pkg::*;
#(
  parameter int NPORT     = 2,
  parameter int HASH_SIZE = db_pkg::HASH_SIZE,
  parameter int KEY_SIZE  = db_pkg::KEY_SIZE,
  parameter int VAL_SIZE  = db_pkg::VAL_SIZE,
  parameter int FLAG_SIZE = db_pkg::FLAG_SIZE,
  parameter int TAG_DEPTH = 8,
  parameter int ISSUE_GAP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            req_valid,
  output logic [NPORT-1:0]            req_ready,
  input  logic [NPORT*FLAG_SIZE-1:0]  req_op,
  input  logic [NPORT*HASH_SIZE-1:0]  req_hash,
  input  logic [NPORT*KEY_SIZE-1:0]   req_key,
  input  logic [NPORT*VAL_SIZE-1:0]   req_value,
  output logic                        db_valid,
  output logic [FLAG_SIZE-1:0]        db_op,
  output logic [HASH_SIZE-1:0]        db_hash,
  output logic [KEY_SIZE-1:0]         db_key,
  output logic [VAL_SIZE-1:0]         db_value,
  input  logic                        db_out_valid,
  input  logic [FLAG_SIZE-1:0]        db_out_flag,
  input  logic [VAL_SIZE-1:0]         db_out_value,
  output logic [NPORT-1:0]            rsp_valid,
  output logic [FLAG_SIZE-1:0]        rsp_flag,
  output logic [VAL_SIZE-1:0]         rsp_value,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        err_orphan,
  output logic [NPORT*32-1:0]         stat_grants
);

  localparam int IW = idx_w(NPORT);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam int GW = idx_w(ISSUE_GAP);

  logic [FLAG_SIZE-1:0] w_op    [NPORT];
  logic [HASH_SIZE-1:0] w_hash  [NPORT];
  logic [KEY_SIZE-1:0]  w_key   [NPORT];
  logic [VAL_SIZE-1:0]  w_value [NPORT];

  for (genvar p = 0; p < NPORT; p++) begin : g_unpack
    assign w_op[p]    = req_op[p*FLAG_SIZE +: FLAG_SIZE];
    assign w_hash[p]  = req_hash[p*HASH_SIZE +: HASH_SIZE];
    assign w_key[p]   = req_key[p*KEY_SIZE +: KEY_SIZE];
    assign w_value[p] = req_value[p*VAL_SIZE +: VAL_SIZE];
  end

  // Returns {found, index}: first valid port searching upward from last+1.
  function automatic logic [IW:0] rr_pick(input logic [NPORT-1:0] vld, input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] idx;
    int            cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = (int'(last) + k) % NPORT;
      if (!found && vld[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NPORT-1:0] onehot(input logic [IW-1:0] idx);
    logic [NPORT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [IW-1:0]        r_last;
  logic [GW-1:0]        r_gap;
  logic                 r_db_valid;
  logic [FLAG_SIZE-1:0] r_db_op;
  logic [HASH_SIZE-1:0] r_db_hash;
  logic [KEY_SIZE-1:0]  r_db_key;
  logic [VAL_SIZE-1:0]  r_db_value;
  logic [NPORT-1:0]     r_rsp_valid;
  logic [FLAG_SIZE-1:0] r_rsp_flag;
  logic [VAL_SIZE-1:0]  r_rsp_value;
  logic                 r_err_orphan;

  logic [IW:0]          w_pick;
  logic                 w_found;
  logic [IW-1:0]        w_sel;
  logic                 w_can_issue;
  logic                 w_hs;
  logic                 w_pop;
  logic [IW-1:0]        w_head;
  logic [CW-1:0]        w_count;

  assign w_pick      = rr_pick(req_valid, r_last);
  assign w_found     = w_pick[IW];
  assign w_sel       = w_pick[IW-1:0];
  // Uses the registered count only: a pop this cycle frees a slot next cycle.
  assign w_can_issue = (w_count < CW'(TAG_DEPTH)) && (r_gap == '0);
  assign w_hs        = w_found && w_can_issue;
  assign w_pop       = db_out_valid && (w_count != '0);
  assign req_ready   = w_hs ? onehot(w_sel) : '0;

  db_tag_fifo #(
    .W     (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_hs),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= IW'(NPORT - 1);
      r_gap        <= '0;
      r_db_valid   <= 1'b0;
      r_db_op      <= '0;
      r_db_hash    <= '0;
      r_db_key     <= '0;
      r_db_value   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_flag   <= '0;
      r_rsp_value  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_db_valid <= w_hs;
      if (w_hs) begin
        r_last     <= w_sel;
        r_gap      <= GW'(ISSUE_GAP - 1);
        r_db_op    <= w_op[w_sel];
        r_db_hash  <= w_hash[w_sel];
        r_db_key   <= w_key[w_sel];
        r_db_value <= w_value[w_sel];
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
      r_rsp_valid <= w_pop ? onehot(w_head) : '0;
      if (db_out_valid) begin
        r_rsp_flag  <= db_out_flag;
        r_rsp_value <= db_out_value;
        if (w_count == '0) r_err_orphan <= 1'b1;
      end
    end
  end

`ifdef DB_ARB_STATS_EN
  logic [31:0] r_stat [NPORT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORT; p++) r_stat[p] <= '0;
    end else if (w_hs) begin
      r_stat[w_sel] <= r_stat[w_sel] + 32'd1;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_stat
    assign stat_grants[p*32 +: 32] = r_stat[p];
  end
`else
  assign stat_grants = '0;
`endif

  assign db_valid    = r_db_valid;
  assign db_op       = r_db_op;
  assign db_hash     = r_db_hash;
  assign db_key      = r_db_key;
  assign db_value    = r_db_value;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_flag    = r_rsp_flag;
  assign rsp_value   = r_rsp_value;
  assign outstanding = w_count;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_db_arb.sv
// Scoreboard bench for db_arb: instance a (TAG_DEPTH=4, gap 1) and instance b (gap 5).
module tb_db_arb;

`ifdef DB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] hash;
    logic [95:0] key;
    logic [31:0] val;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  oh;
    logic [3:0]  flag;
    logic [31:0] val;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // instance a
  logic [1:0]   a_req_valid, a_req_ready;
  logic [7:0]   a_req_op;
  logic [63:0]  a_req_hash;
  logic [191:0] a_req_key;
  logic [63:0]  a_req_value;
  logic         a_db_valid;
  logic [3:0]   a_db_op;
  logic [31:0]  a_db_hash;
  logic [95:0]  a_db_key;
  logic [31:0]  a_db_value;
  logic         a_out_valid;
  logic [3:0]   a_out_flag;
  logic [31:0]  a_out_value;
  logic [1:0]   a_rsp_valid;
  logic [3:0]   a_rsp_flag;
  logic [31:0]  a_rsp_value;
  logic [2:0]   a_outstanding;
  logic         a_err;
  logic [63:0]  a_stat;

  // instance b
  logic [1:0]   b_req_valid, b_req_ready;
  logic         b_db_valid;
  logic [3:0]   b_db_op;
  logic [31:0]  b_db_hash;
  logic [95:0]  b_db_key;
  logic [31:0]  b_db_value;
  logic [1:0]   b_rsp_valid;
  logic [3:0]   b_rsp_flag;
  logic [31:0]  b_rsp_value;
  logic [3:0]   b_outstanding;
  logic         b_err;
  logic [63:0]  b_stat;
  logic         b_out_valid = 1'b0;

  db_arb #(.NPORT(2), .TAG_DEPTH(4), .ISSUE_GAP(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op(a_req_op), .req_hash(a_req_hash), .req_key(a_req_key), .req_value(a_req_value),
    .db_valid(a_db_valid), .db_op(a_db_op), .db_hash(a_db_hash), .db_key(a_db_key), .db_value(a_db_value),
    .db_out_valid(a_out_valid), .db_out_flag(a_out_flag), .db_out_value(a_out_value),
    .rsp_valid(a_rsp_valid), .rsp_flag(a_rsp_flag), .rsp_value(a_rsp_value),
    .outstanding(a_outstanding), .err_orphan(a_err), .stat_grants(a_stat)
  );

  db_arb #(.NPORT(2), .TAG_DEPTH(8), .ISSUE_GAP(5)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(8'h21), .req_hash(64'h0000_0002_0000_0001), .req_key(192'h0), .req_value(64'h0),
    .db_valid(b_db_valid), .db_op(b_db_op), .db_hash(b_db_hash), .db_key(b_db_key), .db_value(b_db_value),
    .db_out_valid(b_out_valid), .db_out_flag(4'h0), .db_out_value(32'h0),
    .rsp_valid(b_rsp_valid), .rsp_flag(b_rsp_flag), .rsp_value(b_rsp_value),
    .outstanding(b_outstanding), .err_orphan(b_err), .stat_grants(b_stat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input cmd_t c);
    a_req_op[p*4 +: 4]       = c.op;
    a_req_hash[p*32 +: 32]   = c.hash;
    a_req_key[p*96 +: 96]    = c.key;
    a_req_value[p*32 +: 32]  = c.val;
  endtask

  function automatic cmd_t mk_cmd(input int p, input int i);
    cmd_t c;
    c.op   = 4'(i + 1);
    c.hash = 32'h5000_0000 | (32'(p) << 8) | 32'(i);
    c.key  = {32'(p), 32'(i), 32'hCAFE_0000};
    c.val  = 32'(p * 100 + i);
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_req_valid = '0;
    a_out_valid = 1'b0;
    b_req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_cmd.delete();
    exp_rsp.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (a_db_valid !== 1'b0) begin n_err++; $display("FAIL reset_db_valid: got %0b want 0", a_db_valid); end
    n_cmp++; if (a_req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", a_req_ready); end
    n_cmp++; if (a_outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", a_outstanding); end
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_orphan: got %0b want 0", a_err); end
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", a_rsp_valid); end
    n_cmp++; if (a_stat !== 64'h0) begin n_err++; $display("FAIL reset_stats: got %h want 0", a_stat); end
    n_cmp++; if ({a_db_op, a_db_hash, a_db_key, a_db_value} !== 164'h0) begin n_err++; $display("FAIL reset_db_payload: got %h want 0", {a_db_op, a_db_hash, a_db_key, a_db_value}); end
  endtask

  task automatic test_single();
    cmd_t c;
    rsp_t r;
    cmd_t e;
    do_reset();
    c = '{op: 4'b0011, hash: 32'h11223344, key: {32'hC0A80A0B, 32'hC0A85057, 32'd12345}, val: 32'h0000_00AB};
    set_port(0, c);
    a_req_valid = 2'b01;
    #1;
    n_cmp++; if (a_req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", a_req_ready); end
    exp_cmd.push_back(c);
    tick();
    a_req_valid = 2'b00;
    n_cmp++; if (a_db_valid !== 1'b1) begin n_err++; $display("FAIL single_db_valid: got %0b want 1", a_db_valid); end
    e = exp_cmd.pop_front();
    n_cmp++; if ({a_db_op, a_db_hash, a_db_key, a_db_value} !== e) begin n_err++; $display("FAIL single_payload: got %h want %h", {a_db_op, a_db_hash, a_db_key, a_db_value}, e); end
    n_cmp++; if (a_outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding1: got %0d want 1", a_outstanding); end
    a_out_valid = 1'b1; a_out_flag = 4'h1; a_out_value = 32'hDEADBEEF;
    exp_rsp.push_back('{oh: 2'b01, flag: 4'h1, val: 32'hDEADBEEF});
    tick();
    a_out_valid = 1'b0;
    n_cmp++; if (a_db_valid !== 1'b0) begin n_err++; $display("FAIL single_db_pulse: got %0b want 0", a_db_valid); end
    r = exp_rsp.pop_front();
    n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL single_rsp: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
    n_cmp++; if (a_outstanding !== 3'd0) begin n_err++; $display("FAIL single_outstanding0: got %0d want 0", a_outstanding); end
    tick();
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_pulse: got %b want 00", a_rsp_valid); end
  endtask

  task automatic test_contention();
    int   rem[2];
    int   idx[2];
    int   last, mout, pick, n_rsp, idle, cyc;
    bit   due;
    logic [1:0] exp_ready;
    cmd_t c;
    rsp_t r;
    do_reset();
    rem[0] = 6; rem[1] = 6; idx[0] = 0; idx[1] = 0;
    last = 1; mout = 0; n_rsp = 0; idle = 0; cyc = 0; due = 1'b0;
    while ((rem[0] + rem[1] > 0) || (exp_cmd.size() > 0) || (exp_rsp.size() > 0)) begin
      if (due) begin
        r = exp_rsp.pop_front();
        n_rsp++;
        n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL cont_rsp: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
      end
      due = 1'b0;
      a_out_valid = 1'b0;
      if (a_db_valid === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL cont_unexpected_db: got db_valid=1 want 0");
        end else begin
          c = exp_cmd.pop_front();
          n_cmp++; if ({a_db_op, a_db_hash, a_db_key, a_db_value} !== c) begin n_err++; $display("FAIL cont_payload: got %h want %h", {a_db_op, a_db_hash, a_db_key, a_db_value}, c); end
          a_out_valid = 1'b1; a_out_flag = c.hash[3:0]; a_out_value = ~c.hash;
          exp_rsp.push_back('{oh: (c.hash[8] ? 2'b10 : 2'b01), flag: c.hash[3:0], val: ~c.hash});
          due = 1'b1;
        end
      end
      n_cmp++; if (a_outstanding !== 3'(mout)) begin n_err++; $display("FAIL cont_outstanding: got %0d want %0d", a_outstanding, mout); end
      for (int p = 0; p < 2; p++) if (rem[p] > 0) set_port(p, mk_cmd(p, idx[p]));
      a_req_valid = {rem[1] > 0, rem[0] > 0};
      #1;
      pick = -1;
      for (int k = 1; k <= 2; k++) if (pick < 0 && a_req_valid[(last + k) % 2]) pick = (last + k) % 2;
      if (mout >= 4) pick = -1;
      exp_ready = (pick >= 0) ? (2'b01 << pick) : 2'b00;
      n_cmp++; if (a_req_ready !== exp_ready) begin n_err++; $display("FAIL cont_ready: got %b want %b", a_req_ready, exp_ready); end
      if (pick >= 0) begin
        exp_cmd.push_back(mk_cmd(pick, idx[pick]));
        idx[pick]++; rem[pick]--; last = pick;
      end else if (rem[0] + rem[1] > 0) begin
        idle++;
      end
      mout = mout + ((pick >= 0) ? 1 : 0) - ((a_out_valid && mout > 0) ? 1 : 0);
      tick();
      cyc++;
      if (cyc > 80) begin
        n_cmp++; n_err++; $display("FAIL cont_timeout: got %0d cycles want <= 80", cyc);
        break;
      end
    end
    a_req_valid = 2'b00;
    a_out_valid = 1'b0;
    n_cmp++; if (n_rsp !== 12) begin n_err++; $display("FAIL cont_rsp_count: got %0d want 12", n_rsp); end
    n_cmp++; if (idle !== 0) begin n_err++; $display("FAIL cont_back_to_back: got %0d idle cycles want 0", idle); end
  endtask

  task automatic test_full();
    cmd_t c;
    cmd_t e;
    rsp_t r;
    do_reset();
    c = mk_cmd(0, 7);
    set_port(0, c);
    a_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (a_req_ready !== 2'b01) begin n_err++; $display("FAIL full_fill_ready: got %b want 01", a_req_ready); end
      exp_cmd.push_back(c);
      tick();
      e = exp_cmd.pop_front();
      n_cmp++; if ({a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value} !== {1'b1, e}) begin n_err++; $display("FAIL full_fill_db: got %h want %h", {a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value}, {1'b1, e}); end
    end
    #1;
    n_cmp++; if (a_req_ready !== 2'b00) begin n_err++; $display("FAIL full_ready: got %b want 00", a_req_ready); end
    n_cmp++; if (a_outstanding !== 3'd4) begin n_err++; $display("FAIL full_outstanding: got %0d want 4", a_outstanding); end
    a_out_valid = 1'b1; a_out_flag = 4'h2; a_out_value = 32'h0000_0001;
    exp_rsp.push_back('{oh: 2'b01, flag: 4'h2, val: 32'h0000_0001});
    #1;
    n_cmp++; if (a_req_ready !== 2'b00) begin n_err++; $display("FAIL full_no_bypass: got %b want 00", a_req_ready); end
    tick();
    r = exp_rsp.pop_front();
    n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL full_rsp1: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
    n_cmp++; if (a_outstanding !== 3'd3) begin n_err++; $display("FAIL full_after_pop: got %0d want 3", a_outstanding); end
    n_cmp++; if (a_req_ready !== 2'b01) begin n_err++; $display("FAIL full_ready_back: got %b want 01", a_req_ready); end
    exp_cmd.push_back(c);
    a_out_value = 32'h0000_0002;
    exp_rsp.push_back('{oh: 2'b01, flag: 4'h2, val: 32'h0000_0002});
    tick();
    e = exp_cmd.pop_front();
    n_cmp++; if ({a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value} !== {1'b1, e}) begin n_err++; $display("FAIL full_pushpop_db: got %h want %h", {a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value}, {1'b1, e}); end
    r = exp_rsp.pop_front();
    n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL full_rsp2: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
    n_cmp++; if (a_outstanding !== 3'd3) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 3", a_outstanding); end
    a_out_valid = 1'b0;
    exp_cmd.push_back(c);
    tick();
    a_req_valid = 2'b00;
    e = exp_cmd.pop_front();
    n_cmp++; if ({a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value} !== {1'b1, e}) begin n_err++; $display("FAIL full_refill_db: got %h want %h", {a_db_valid, a_db_op, a_db_hash, a_db_key, a_db_value}, {1'b1, e}); end
    n_cmp++; if (a_outstanding !== 3'd4) begin n_err++; $display("FAIL full_refill_count: got %0d want 4", a_outstanding); end
    for (int i = 0; i < 4; i++) begin
      a_out_valid = 1'b1; a_out_flag = 4'h1; a_out_value = 32'(i + 16);
      exp_rsp.push_back('{oh: 2'b01, flag: 4'h1, val: 32'(i + 16)});
      tick();
      a_out_valid = 1'b0;
      r = exp_rsp.pop_front();
      n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL full_drain_rsp: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
    end
    n_cmp++; if (a_outstanding !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", a_outstanding); end
  endtask

  task automatic test_issue_gap();
    int pulses[$];
    do_reset();
    b_req_valid = 2'b01;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (b_db_valid === 1'b1) pulses.push_back(i);
    end
    b_req_valid = 2'b00;
    n_cmp++; if (pulses.size() !== 8) begin n_err++; $display("FAIL gap_pulse_count: got %0d want 8", pulses.size()); end
    if (pulses.size() > 0) begin
      n_cmp++; if (pulses[0] !== 1) begin n_err++; $display("FAIL gap_first_pulse: got cycle %0d want 1", pulses[0]); end
    end
    for (int i = 1; i < pulses.size(); i++) begin
      n_cmp++; if (pulses[i] - pulses[i-1] !== 5) begin n_err++; $display("FAIL gap_spacing: got %0d want 5", pulses[i] - pulses[i-1]); end
    end
    n_cmp++; if (b_outstanding !== 4'd8) begin n_err++; $display("FAIL gap_outstanding: got %0d want 8", b_outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    a_out_valid = 1'b1; a_out_flag = 4'h8; a_out_value = 32'h1234_5678;
    tick();
    a_out_valid = 1'b0;
    n_cmp++; if (a_err !== 1'b1) begin n_err++; $display("FAIL orphan_flag: got %0b want 1", a_err); end
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_err++; $display("FAIL orphan_rsp: got %b want 00", a_rsp_valid); end
    n_cmp++; if (a_outstanding !== 3'd0) begin n_err++; $display("FAIL orphan_outstanding: got %0d want 0", a_outstanding); end
    tick();
    n_cmp++; if (a_err !== 1'b1) begin n_err++; $display("FAIL orphan_sticky: got %0b want 1", a_err); end
    do_reset();
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL orphan_cleared: got %0b want 0", a_err); end
  endtask

  task automatic test_reset_stats();
    rsp_t r;
    do_reset();
    set_port(0, mk_cmd(0, 1));
    set_port(1, mk_cmd(1, 2));
    a_req_valid = 2'b01;
    tick(); tick(); tick();
    a_req_valid = 2'b00;
    n_cmp++; if (a_outstanding !== 3'd3) begin n_err++; $display("FAIL rs_outstanding3: got %0d want 3", a_outstanding); end
    n_cmp++; if (a_stat[31:0] !== (STATS ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL rs_stat_p0: got %0d want %0d", a_stat[31:0], STATS ? 3 : 0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (a_outstanding !== 3'd0) begin n_err++; $display("FAIL rs_outstanding_rst: got %0d want 0", a_outstanding); end
    n_cmp++; if (a_stat !== 64'h0) begin n_err++; $display("FAIL rs_stat_rst: got %h want 0", a_stat); end
    n_cmp++; if (a_db_valid !== 1'b0) begin n_err++; $display("FAIL rs_db_valid_rst: got %0b want 0", a_db_valid); end
    a_req_valid = 2'b10;
    tick(); tick();
    a_req_valid = 2'b00;
    n_cmp++; if (a_stat[63:32] !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL rs_stat_p1: got %0d want %0d", a_stat[63:32], STATS ? 2 : 0); end
    n_cmp++; if (a_stat[31:0] !== 32'd0) begin n_err++; $display("FAIL rs_stat_p0_zero: got %0d want 0", a_stat[31:0]); end
    n_cmp++; if (a_outstanding !== 3'd2) begin n_err++; $display("FAIL rs_outstanding2: got %0d want 2", a_outstanding); end
    a_out_valid = 1'b1; a_out_flag = 4'h1; a_out_value = 32'h0000_0BEE;
    exp_rsp.push_back('{oh: 2'b10, flag: 4'h1, val: 32'h0000_0BEE});
    tick();
    a_out_valid = 1'b0;
    r = exp_rsp.pop_front();
    n_cmp++; if ({a_rsp_valid, a_rsp_flag, a_rsp_value} !== r) begin n_err++; $display("FAIL rs_rsp_port1: got %h want %h", {a_rsp_valid, a_rsp_flag, a_rsp_value}, r); end
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = '0; a_req_op = '0; a_req_hash = '0; a_req_key = '0; a_req_value = '0;
    a_out_valid = 1'b0; a_out_flag = '0; a_out_value = '0;
    b_req_valid = '0;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_issue_gap();
    test_orphan();
    test_reset_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
